// File: rtl/circle_ctrl.sv
// Midpoint-circle sequencing FSM: walks the datapath through init, per-iteration
// eight-octant plotting, step decision and offset/criterion update.
module circle_ctrl #(
  parameter int OFFSET_X_DW = 9,
  parameter int OFFSET_Y_DW = 8,
  parameter int CRIT_DW     = 9
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  output logic                   done,
  input  logic [OFFSET_X_DW-1:0] offset_x,
  input  logic [OFFSET_Y_DW-1:0] offset_y,
  input  logic [CRIT_DW-1:0]     crit,
  output logic [2:0]             octant_sel,
  output logic                   plot_en,
  output logic                   load_x_init,
  output logic                   load_y_init,
  output logic                   load_crit,
  output logic                   inc_y,
  output logic                   dec_x,
  output logic                   calc_crit,
  output logic                   load_x_next,
  output logic                   load_y_next,
  output logic [2:0]             state_dbg
);

  // start/done is a level handshake: start is held until done is seen, and
  // done is held until start drops; a draw never aborts once it has begun.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    CHECK  = 3'd2,
    PLOT   = 3'd3,
    STEP   = 3'd4,
    UPDATE = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] oct_q, oct_d;

  logic signed [OFFSET_Y_DW-1:0] oy_s;
  logic signed [OFFSET_X_DW-1:0] oy_ext;
  logic signed [OFFSET_X_DW-1:0] ox_s;
  logic                          crit_pos;

  assign oy_s     = offset_y;
  assign oy_ext   = OFFSET_X_DW'(oy_s);
  assign ox_s     = offset_x;
  assign crit_pos = !crit[CRIT_DW-1] && (crit != '0);

  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      oct_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      oct_q   <= oct_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    oct_d       = oct_q;
    done        = 1'b0;
    octant_sel  = 3'd0;
    plot_en     = 1'b0;
    load_x_init = 1'b0;
    load_y_init = 1'b0;
    load_crit   = 1'b0;
    inc_y       = 1'b0;
    dec_x       = 1'b0;
    calc_crit   = 1'b0;
    load_x_next = 1'b0;
    load_y_next = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        load_x_init = 1'b1;
        load_y_init = 1'b1;
        load_crit   = 1'b1;
        state_d     = CHECK;
      end
      CHECK: begin
        if (oy_ext <= ox_s) begin
          state_d = PLOT;
          oct_d   = 3'd0;
        end else begin
          state_d = DONE;
        end
      end
      PLOT: begin
        plot_en    = 1'b1;
        octant_sel = oct_q;
        if (oct_q == 3'd7) begin
          state_d = STEP;
          oct_d   = 3'd0;
        end else begin
          oct_d = oct_q + 3'd1;
        end
      end
      STEP: begin
        // crit here is the value the datapath folds in at the UPDATE edge.
        inc_y   = 1'b1;
        dec_x   = crit_pos;
        state_d = UPDATE;
      end
      UPDATE: begin
        calc_crit   = 1'b1;
        load_x_next = 1'b1;
        load_y_next = 1'b1;
        state_d     = CHECK;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_circle_ctrl.sv
// Bench for circle_ctrl: a cycle-level datapath stand-in around the DUT and an
// arithmetic midpoint-circle reference that predicts pixels, step decisions and latency.
module tb_circle_ctrl;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic done, plot_en, load_x_init, load_y_init, load_crit;
  logic inc_y, dec_x, calc_crit, load_x_next, load_y_next;
  logic [2:0] octant_sel, state_dbg;

  logic signed [XW-1:0] dp_x = '0;
  logic signed [XW-1:0] calc_x = '0;
  logic signed [YW-1:0] dp_y = '0;
  logic signed [YW-1:0] calc_y = '0;
  logic signed [CW-1:0] dp_crit = '0;
  logic dec_q = 1'b0;
  int radius = 0;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [19:0] exp_pix_q[$];
  logic [19:0] got_pix_q[$];
  logic        exp_dec_q[$];
  logic        got_dec_q[$];
  int exp_n, exp_fx, exp_fy, exp_fcrit;

  always #5 clk = ~clk;

  circle_ctrl #(.OFFSET_X_DW(XW), .OFFSET_Y_DW(YW), .CRIT_DW(CW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .done(done),
    .offset_x(dp_x), .offset_y(dp_y), .crit(dp_crit),
    .octant_sel(octant_sel), .plot_en(plot_en),
    .load_x_init(load_x_init), .load_y_init(load_y_init), .load_crit(load_crit),
    .inc_y(inc_y), .dec_x(dec_x), .calc_crit(calc_crit),
    .load_x_next(load_x_next), .load_y_next(load_y_next),
    .state_dbg(state_dbg)
  );

  // Datapath stand-in: step controls are registered into calc_*, then loaded.
  always @(posedge clk) begin
    calc_x <= XW'(int'(dp_x) - int'(dec_x));
    calc_y <= YW'(int'(dp_y) + int'(inc_y));
    dec_q  <= dec_x;
    if (load_x_init) dp_x <= XW'(radius);
    if (load_y_init) dp_y <= '0;
    if (load_crit)   dp_crit <= CW'(1 - radius);
    if (load_x_next) dp_x <= calc_x;
    if (load_y_next) dp_y <= calc_y;
    if (calc_crit) begin
      if (dec_q) dp_crit <= CW'(int'(dp_crit) + 2 * (int'(calc_y) - int'(calc_x)) + 1);
      else       dp_crit <= CW'(int'(dp_crit) + 2 * int'(calc_y) + 1);
    end
  end

  function automatic logic [12:0] outs();
    return {done, plot_en, load_x_init, load_y_init, load_crit, inc_y, dec_x,
            calc_crit, load_x_next, load_y_next, octant_sel};
  endfunction

  task automatic model(input int r);
    int x, y, c;
    exp_pix_q.delete();
    exp_dec_q.delete();
    exp_n = 0;
    x = r; y = 0; c = 1 - r;
    while (y <= x) begin
      exp_n++;
      for (int k = 0; k < 8; k++) exp_pix_q.push_back({3'(k), 9'(x), 8'(y)});
      y++;
      if (c > 0) begin
        x--;
        c += 2 * (y - x) + 1;
        exp_dec_q.push_back(1'b1);
      end else begin
        c += 2 * y + 1;
        exp_dec_q.push_back(1'b0);
      end
    end
    exp_fx = x; exp_fy = y; exp_fcrit = c;
  endtask

  // Raises start, then observes every cycle until done (bounded).
  task automatic do_draw(input int r, input int drop_k, output int done_k, output int viol);
    int grp;
    radius = r;
    got_pix_q.delete();
    got_dec_q.delete();
    viol = 0;
    done_k = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 3000 && done_k < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (plot_en) got_pix_q.push_back({octant_sel, dp_x, dp_y});
      if (inc_y) got_dec_q.push_back(dec_x);
      grp = int'(load_x_init | load_y_init | load_crit) + int'(plot_en) +
            int'(inc_y | dec_x) + int'(calc_crit | load_x_next | load_y_next) + int'(done);
      if (grp > 1) viol++;
      if (load_x_init != load_y_init || load_y_init != load_crit) viol++;
      if (calc_crit != load_x_next || load_x_next != load_y_next) viol++;
      if (dec_x && !inc_y) viol++;
      if (!plot_en && octant_sel != 3'd0) viol++;
      if (done) done_k = k;
      if (k == drop_k) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    int found;
    int dk, v;
    resetn = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (outs() !== 13'd0) $display("FAIL reset_outs got=%h exp=0", outs());
    else pass_cnt++;
    resetn = 1'b1;
    radius = 3;
    start = 1'b1;
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (plot_en && octant_sel == 3'd4) found = 1;
    end
    chk_cnt++;
    if (found !== 1) $display("FAIL reach_oct4 got=%0d exp=1", found);
    else pass_cnt++;
    resetn = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (outs() !== 13'd0) $display("FAIL midplot_reset got=%h exp=0", outs());
    else pass_cnt++;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (outs() !== 13'd0) $display("FAIL idle_after_reset got=%h exp=0", outs());
    else pass_cnt++;
    model(0);
    do_draw(0, -1, dk, v);
    chk_cnt++;
    if (dk !== 14) $display("FAIL post_reset_done_edge got=%0d exp=14", dk);
    else pass_cnt++;
    chk_cnt++;
    if (got_pix_q !== exp_pix_q) $display("FAIL post_reset_octants got_n=%0d exp_n=%0d", got_pix_q.size(), exp_pix_q.size());
    else pass_cnt++;
    @(negedge clk) start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_radius0();
    int dk, v;
    model(0);
    do_draw(0, -1, dk, v);
    chk_cnt++;
    if (dk !== 11 * exp_n + 3) $display("FAIL r0_done_edge got=%0d exp=%0d", dk, 11 * exp_n + 3);
    else pass_cnt++;
    chk_cnt++;
    if (got_pix_q !== exp_pix_q) $display("FAIL r0_pixels got_n=%0d exp_n=%0d", got_pix_q.size(), exp_pix_q.size());
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_cnt++;
      if (done !== 1'b1) $display("FAIL r0_done_hold cyc=%0d got=%b exp=1", i, done);
      else pass_cnt++;
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (outs() !== 13'd0) $display("FAIL r0_back_idle got=%h exp=0", outs());
    else pass_cnt++;
    chk_cnt++;
    if (v !== 0) $display("FAIL r0_strobe_excl got=%0d exp=0", v);
    else pass_cnt++;
  endtask

  task automatic test_small(input int r);
    int dk, v;
    model(r);
    do_draw(r, -1, dk, v);
    chk_cnt++;
    if (dk !== 11 * exp_n + 3) $display("FAIL r%0d_done_edge got=%0d exp=%0d", r, dk, 11 * exp_n + 3);
    else pass_cnt++;
    chk_cnt++;
    if (got_dec_q !== exp_dec_q) $display("FAIL r%0d_dec_pattern got_n=%0d exp_n=%0d", r, got_dec_q.size(), exp_dec_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (got_pix_q !== exp_pix_q) $display("FAIL r%0d_pixels got_n=%0d exp_n=%0d", r, got_pix_q.size(), exp_pix_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (int'(dp_x) !== exp_fx || int'(dp_y) !== exp_fy || int'(dp_crit) !== exp_fcrit)
      $display("FAIL r%0d_final got=%0d,%0d,%0d exp=%0d,%0d,%0d", r, dp_x, dp_y, dp_crit, exp_fx, exp_fy, exp_fcrit);
    else pass_cnt++;
    chk_cnt++;
    if (v !== 0) $display("FAIL r%0d_strobe_excl got=%0d exp=0", r, v);
    else pass_cnt++;
    @(negedge clk) start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_radius50();
    test_small(50);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) test_small(int'($urandom_range(3, 60)));
  endtask

  task automatic test_start_drop();
    int dk, v;
    model(10);
    do_draw(10, 29, dk, v);
    chk_cnt++;
    if (dk !== 11 * exp_n + 3) $display("FAIL drop_done_edge got=%0d exp=%0d", dk, 11 * exp_n + 3);
    else pass_cnt++;
    chk_cnt++;
    if (got_pix_q !== exp_pix_q) $display("FAIL drop_pixels got_n=%0d exp_n=%0d", got_pix_q.size(), exp_pix_q.size());
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (outs() !== 13'd0) $display("FAIL drop_done_pulse got=%h exp=0", outs());
    else pass_cnt++;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_radius0();
    test_small(1);
    test_small(2);
    test_radius50();
    test_random();
    test_start_drop();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
